// File: rtl/seq_monitor.sv
// Checks that {in0,in1} steps 00->01->10->11->00 every clock, tracks lock,
// counts locked wraps and sequence errors, and registers in0 & in1.
module seq_monitor #(
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0,
    input  logic             in1,
    input  logic             clr,
    output logic             and_out,
    output logic             lock,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int              MW     = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]   LOCK_V = MW'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HUNT = 2'b01,
        LOCK = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       prev_q, prev_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic             and_out_q, and_out_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [1:0]       s;
    logic [1:0]       nxt;
    logic             match;
    logic [MW-1:0]    match_inc;

    assign s         = {in0, in1};
    assign nxt       = prev_q + 2'd1;
    assign match     = (s == nxt);
    assign match_inc = match_cnt_q + MW'(1);

    always_comb begin
        state_d     = state_q;
        prev_d      = s;
        match_cnt_d = match_cnt_q;
        and_out_d   = in0 & in1;
        err_d       = 1'b0;
        cycle_cnt_d = cycle_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (clr) begin
            state_d     = IDLE;
            match_cnt_d = '0;
            cycle_cnt_d = '0;
            err_cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = HUNT;
                    match_cnt_d = '0;
                end
                HUNT: begin
                    if (match) begin
                        match_cnt_d = match_inc;
                        if (match_inc == LOCK_V) begin
                            state_d = LOCK;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCK: begin
                    if (match) begin
                        // match with prev == 11 implies s == 00: a full wrap
                        if (prev_q == 2'b11) begin
                            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_d       = 1'b1;
                        state_d     = HUNT;
                        match_cnt_d = '0;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    match_cnt_d = '0;
                end
            endcase
        end

        lock_d = (state_d == LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_q      <= 2'b00;
            match_cnt_q <= '0;
            and_out_q   <= 1'b0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
            cycle_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_cnt_q <= match_cnt_d;
            and_out_q   <= and_out_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
            cycle_cnt_q <= cycle_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign and_out   = and_out_q;
    assign lock      = lock_q;
    assign err       = err_q;
    assign cycle_cnt = cycle_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor: default instance plus a CNT_W=3 instance
// sharing the same stimulus for wrap and saturation boundaries.
module tb_seq_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in0;
    logic       in1;
    logic       clr;

    logic       and_out, lock, err;
    logic [7:0] cycle_cnt, err_cnt;

    logic       and_out3, lock3, err3;
    logic [2:0] cycle_cnt3, err_cnt3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_monitor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .clr       (clr),
        .and_out   (and_out),
        .lock      (lock),
        .err       (err),
        .cycle_cnt (cycle_cnt),
        .err_cnt   (err_cnt)
    );

    seq_monitor #(.LOCK_CNT(4), .CNT_W(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .clr       (clr),
        .and_out   (and_out3),
        .lock      (lock3),
        .err       (err3),
        .cycle_cnt (cycle_cnt3),
        .err_cnt   (err_cnt3)
    );

    task automatic step(input logic [1:0] v, input logic c);
        {in0, in1} = v;
        clr        = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_clean(input string tag);
        logic [1:0] v;
        logic       exp_l;
        logic       exp_a;
        for (int e = 1; e <= 13; e++) begin
            v     = 2'((e - 1) % 4);
            exp_l = (e >= 5);
            exp_a = (v == 2'd3);
            step(v, 1'b0);
            checks++;
            if (lock !== exp_l) begin
                errors++;
                $display("FAIL %s lock e%0d: got %b want %b", tag, e, lock, exp_l);
            end
            checks++;
            if (and_out !== exp_a) begin
                errors++;
                $display("FAIL %s and_out e%0d: got %b want %b", tag, e, and_out, exp_a);
            end
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL %s err e%0d: got %b want 0", tag, e, err);
            end
            if (e == 5 || e == 8) begin
                checks++;
                if (cycle_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL %s cycle e%0d: got %0d want 0", tag, e, cycle_cnt);
                end
            end
            if (e == 9) begin
                checks++;
                if (cycle_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL %s cycle e9: got %0d want 1", tag, cycle_cnt);
                end
            end
            if (e == 13) begin
                checks++;
                if (cycle_cnt !== 8'd2) begin
                    errors++;
                    $display("FAIL %s cycle e13: got %0d want 2", tag, cycle_cnt);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        {in0, in1} = 2'b00;
        clr        = 1'b0;
        #23;
        checks++;
        if ({and_out, lock, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset flags: got %b want 000", {and_out, lock, err});
        end
        checks++;
        if (cycle_cnt !== 8'd0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset cnts: got %0d/%0d want 0/0", cycle_cnt, err_cnt);
        end
        checks++;
        if (dut.state_q !== 2'b00 || dut.prev_q !== 2'b00) begin
            errors++;
            $display("FAIL reset state: got %b/%b want 00/00", dut.state_q, dut.prev_q);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean();
        run_clean("clean");
    endtask

    // Locked with prev=00: feed 01, then 00 where 10 is due.
    task automatic test_error_inject();
        step(2'd1, 1'b0);
        step(2'd0, 1'b0);
        checks++;
        if (err !== 1'b1 || lock !== 1'b0) begin
            errors++;
            $display("FAIL inj err/lock: got %b/%b want 1/0", err, lock);
        end
        checks++;
        if (err_cnt !== 8'd1 || cycle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL inj cnts: got %0d/%0d want 1/2", err_cnt, cycle_cnt);
        end
        step(2'd1, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL inj err width: got %b want 0", err);
        end
        step(2'd2, 1'b0);
        step(2'd3, 1'b0);
        checks++;
        if (lock !== 1'b0) begin
            errors++;
            $display("FAIL inj early lock: got %b want 0", lock);
        end
        step(2'd0, 1'b0);
        checks++;
        if (lock !== 1'b1 || cycle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL inj relock: got %b/%0d want 1/2", lock, cycle_cnt);
        end
    endtask

    task automatic test_hunt_repeat();
        step(2'd0, 1'b0);
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL rep enter: got %b/%0d want 1/2", err, err_cnt);
        end
        step(2'd1, 1'b0);
        checks++;
        if (dut.match_cnt_q !== 3'd1) begin
            errors++;
            $display("FAIL rep mcnt1: got %0d want 1", dut.match_cnt_q);
        end
        step(2'd1, 1'b0);
        checks++;
        if (err !== 1'b0 || dut.match_cnt_q !== 3'd0) begin
            errors++;
            $display("FAIL rep repeat: got %b/%0d want 0/0", err, dut.match_cnt_q);
        end
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL rep errcnt: got %0d want 2", err_cnt);
        end
        step(2'd2, 1'b0);
        step(2'd3, 1'b0);
        step(2'd0, 1'b0);
        checks++;
        if (lock !== 1'b0 || cycle_cnt !== 8'd2) begin
            errors++;
            $display("FAIL rep delayed: got %b/%0d want 0/2", lock, cycle_cnt);
        end
        step(2'd1, 1'b0);
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("FAIL rep lock: got %b want 1", lock);
        end
    endtask

    task automatic test_narrow_counters();
        logic [2:0] exp_c;
        logic [2:0] exp_e;
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        step(2'd0, 1'b0);
        step(2'd1, 1'b0);
        step(2'd2, 1'b0);
        step(2'd3, 1'b0);
        step(2'd0, 1'b0);
        checks++;
        if (lock3 !== 1'b1 || cycle_cnt3 !== 3'd0) begin
            errors++;
            $display("FAIL n3 lock: got %b/%0d want 1/0", lock3, cycle_cnt3);
        end
        for (int w = 1; w <= 8; w++) begin
            step(2'd1, 1'b0);
            step(2'd2, 1'b0);
            step(2'd3, 1'b0);
            step(2'd0, 1'b0);
            exp_c = 3'(w % 8);
            checks++;
            if (cycle_cnt3 !== exp_c) begin
                errors++;
                $display("FAIL n3 wrap %0d: got %0d want %0d", w, cycle_cnt3, exp_c);
            end
        end
        checks++;
        if (cycle_cnt !== 8'd8) begin
            errors++;
            $display("FAIL n8 wraps: got %0d want 8", cycle_cnt);
        end
        for (int i = 1; i <= 9; i++) begin
            step(2'd0, 1'b0);
            exp_e = (i < 7) ? 3'(i) : 3'd7;
            checks++;
            if (err3 !== 1'b1 || lock3 !== 1'b0) begin
                errors++;
                $display("FAIL n3 ep%0d err/lock: got %b/%b want 1/0", i, err3, lock3);
            end
            checks++;
            if (err_cnt3 !== exp_e) begin
                errors++;
                $display("FAIL n3 ep%0d errcnt: got %0d want %0d", i, err_cnt3, exp_e);
            end
            step(2'd1, 1'b0);
            step(2'd2, 1'b0);
            step(2'd3, 1'b0);
            step(2'd0, 1'b0);
            checks++;
            if (lock3 !== 1'b1 || err3 !== 1'b0) begin
                errors++;
                $display("FAIL n3 ep%0d relock: got %b/%b want 1/0", i, lock3, err3);
            end
        end
        checks++;
        if (cycle_cnt3 !== 3'd0 || err_cnt !== 8'd9) begin
            errors++;
            $display("FAIL n3 end: got %0d/%0d want 0/9", cycle_cnt3, err_cnt);
        end
    endtask

    // Locked with prev=00 and counters nonzero; clr on a mismatching edge.
    task automatic test_clr_priority();
        step(2'd0, 1'b1);
        checks++;
        if (err !== 1'b0 || lock !== 1'b0) begin
            errors++;
            $display("FAIL clr err/lock: got %b/%b want 0/0", err, lock);
        end
        checks++;
        if (cycle_cnt !== 8'd0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr cnts: got %0d/%0d want 0/0", cycle_cnt, err_cnt);
        end
        checks++;
        if (dut.state_q !== 2'b00 || dut.match_cnt_q !== 3'd0) begin
            errors++;
            $display("FAIL clr state: got %b/%0d want 00/0", dut.state_q, dut.match_cnt_q);
        end
        step(2'd1, 1'b0);
        checks++;
        if (dut.state_q !== 2'b01 || lock !== 1'b0) begin
            errors++;
            $display("FAIL clr capture: got %b/%b want 01/0", dut.state_q, lock);
        end
        step(2'd2, 1'b0);
        step(2'd3, 1'b0);
        step(2'd0, 1'b0);
        checks++;
        if (lock !== 1'b0) begin
            errors++;
            $display("FAIL clr early lock: got %b want 0", lock);
        end
        step(2'd1, 1'b0);
        checks++;
        if (lock !== 1'b1 || cycle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr relock: got %b/%0d want 1/0", lock, cycle_cnt);
        end
    endtask

    task automatic test_async_reset();
        step(2'd2, 1'b0);
        step(2'd3, 1'b0);
        step(2'd0, 1'b0);
        step(2'd1, 1'b0);
        step(2'd2, 1'b0);
        step(2'd3, 1'b0);
        checks++;
        if (and_out !== 1'b1 || lock !== 1'b1 || cycle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL arst pre: got %b/%b/%0d want 1/1/1", and_out, lock, cycle_cnt);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({and_out, lock, err} !== 3'b000) begin
            errors++;
            $display("FAIL arst flags: got %b want 000", {and_out, lock, err});
        end
        checks++;
        if (cycle_cnt !== 8'd0 || err_cnt3 !== 3'd0) begin
            errors++;
            $display("FAIL arst cnts: got %0d/%0d want 0/0", cycle_cnt, err_cnt3);
        end
        checks++;
        if (dut.state_q !== 2'b00 || dut.prev_q !== 2'b00) begin
            errors++;
            $display("FAIL arst state: got %b/%b want 00/00", dut.state_q, dut.prev_q);
        end
        {in0, in1} = 2'b00;
        #10;
        rst_n = 1'b1;
        run_clean("post_rst");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_error_inject();
        test_hunt_repeat();
        test_narrow_counters();
        test_clr_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
